reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter_2.sv | 18 +
 rtl/reg_bank_arbiter.sv | 118 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// rtl/reg_bank_arbiter_pkg.sv - shared FSM states, requester indices and address-width helper
package reg_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int REQ_SPI   = 0;
  localparam int REQ_LOCAL = 1;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - combinational two-way round-robin pick, loser of the last grant wins ties
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_owner ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-requester arbiter in front of a single-port register bank
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 8,
  parameter int MAX_BURST = 4,
  localparam int AW = addr_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ena,
  input  logic [1:0]             req,
  input  logic [1:0]             lock,
  input  logic [1:0]             we,
  input  logic [2*AW-1:0]        addr,
  input  logic [2*REG_WIDTH-1:0] wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic [REG_WIDTH-1:0]   rdata,
  output logic                   bank_en,
  output logic                   bank_we,
  output logic [AW-1:0]          bank_addr,
  output logic [REG_WIDTH-1:0]   bank_wdata,
  input  logic [REG_WIDTH-1:0]   bank_rdata
);

  localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

  state_e                 state;
  logic                   owner;
  logic                   last_owner;
  logic [1:0]             gnt_q;
  logic [BW-1:0]          burst_cnt;
  logic                   cmd_we;
  logic [AW-1:0]          cmd_addr;
  logic [REG_WIDTH-1:0]   cmd_wdata;

  logic [1:0]             winner;
  logic                   src;
  logic                   src_we;
  logic [AW-1:0]          src_addr;
  logic [REG_WIDTH-1:0]   src_wdata;
  logic                   burst_more;
  logic                   in_access;
  logic                   in_resp;

  rr_arbiter_2 u_rr (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // Command source: the fresh winner when arbitrating, the current owner when continuing a burst.
  assign src       = (state == ST_IDLE) ? winner[REQ_LOCAL] : owner;
  assign src_we    = we[src];
  assign src_addr  = src ? addr[REQ_LOCAL*AW +: AW] : addr[REQ_SPI*AW +: AW];
  assign src_wdata = src ? wdata[REQ_LOCAL*REG_WIDTH +: REG_WIDTH]
                         : wdata[REQ_SPI*REG_WIDTH +: REG_WIDTH];

  assign burst_more = lock[owner] && req[owner] && (burst_cnt < BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt_q      <= 2'b00;
      burst_cnt  <= '0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state      <= ST_ACCESS;
            owner      <= src;
            last_owner <= src;
            gnt_q      <= winner;
            burst_cnt  <= '0;
            cmd_we     <= src_we;
            cmd_addr   <= src_addr;
            cmd_wdata  <= src_wdata;
          end
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP: begin
          if (burst_more) begin
            state     <= ST_ACCESS;
            burst_cnt <= burst_cnt + 1'b1;
            cmd_we    <= src_we;
            cmd_addr  <= src_addr;
            cmd_wdata <= src_wdata;
          end else begin
            state     <= ST_IDLE;
            gnt_q     <= 2'b00;
            burst_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset silences them at once.
  assign in_access  = ena && (state == ST_ACCESS);
  assign in_resp    = ena && (state == ST_RESP);

  assign gnt        = gnt_q;
  assign bank_en    = in_access;
  assign bank_we    = in_access && cmd_we;
  assign bank_addr  = cmd_addr;
  assign bank_wdata = cmd_wdata;
  assign rvalid     = in_resp ? gnt_q : 2'b00;
  assign rdata      = in_resp ? (cmd_we ? cmd_wdata : bank_rdata) : '0;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  localparam int NR = 16;
  localparam int RW = 8;
  localparam int MB = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          ena = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [1:0]    lock = 2'b00;
  logic [1:0]    we = 2'b00;
  logic [2*AW-1:0] addr = '0;
  logic [2*RW-1:0] wdata = '0;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [RW-1:0] rdata;
  logic          bank_en;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [RW-1:0] bank_wdata;
  logic [RW-1:0] bank_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NUM_REGS(NR), .REG_WIDTH(RW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  function automatic logic [RW-1:0] seed(input int a);
    return RW'(8'h10 + a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port bank, one-cycle read latency; unwritten words read as a fixed seed.
  logic [RW-1:0] bank_mem [NR];
  logic [NR-1:0] bank_written = '0;
  always @(posedge clk) begin
    if (bank_en) begin
      if (bank_we) begin
        bank_mem[bank_addr]     <= bank_wdata;
        bank_written[bank_addr] <= 1'b1;
      end else begin
        bank_rdata <= bank_written[bank_addr] ? bank_mem[bank_addr] : seed(int'(bank_addr));
      end
    end
  end

  // Transaction model: slot 0 = free, 1 = bank cycle, 2 = response cycle.
  int            m_slot = 0;
  bit            m_owner = 1'b0;
  bit            m_last = 1'b1;
  int            m_beats = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [RW-1:0] m_wdata = '0;
  logic [RW-1:0] m_mem [NR];
  logic [NR-1:0] m_written = '0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_slot = 0; m_owner = 1'b0; m_last = 1'b1; m_beats = 0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (ena) begin
      if (m_slot == 0) begin
        if (req != 2'b00) begin
          m_owner = (req == 2'b11) ? !m_last : req[1];
          m_last  = m_owner;
          m_beats = 1;
          m_we    = we[m_owner];
          m_addr  = addr[m_owner*AW +: AW];
          m_wdata = wdata[m_owner*RW +: RW];
          m_slot  = 1;
        end
      end else if (m_slot == 1) begin
        if (m_we) begin
          m_mem[m_addr]     = m_wdata;
          m_written[m_addr] = 1'b1;
        end
        m_slot = 2;
      end else if (lock[m_owner] && req[m_owner] && m_beats < MB) begin
        m_beats = m_beats + 1;
        m_we    = we[m_owner];
        m_addr  = addr[m_owner*AW +: AW];
        m_wdata = wdata[m_owner*RW +: RW];
        m_slot  = 1;
      end else begin
        m_slot = 0;
      end
    end
  end

  logic [1:0]    e_gnt;
  logic [1:0]    e_rv;
  logic          e_ben;
  logic [RW-1:0] e_rd;
  always @(negedge clk) begin
    e_gnt = (m_slot != 0) ? (2'b01 << m_owner) : 2'b00;
    e_rv  = (m_slot == 2 && ena) ? e_gnt : 2'b00;
    e_ben = (m_slot == 1) && ena;
    e_rd  = m_we ? m_wdata : (m_written[m_addr] ? m_mem[m_addr] : seed(int'(m_addr)));
    check("gnt", gnt, e_gnt);
    check("rvalid", rvalid, e_rv);
    check("bank_en", bank_en, e_ben);
    if (e_rv != 2'b00) check("rdata", rdata, e_rd);
    if (e_ben) begin
      check("bank_we", bank_we, m_we);
      check("bank_addr", bank_addr, m_addr);
      if (m_we) check("bank_wdata", bank_wdata, m_wdata);
    end
    check("gnt_onehot", ($countones(gnt) <= 1), 1);
    check("rvalid_in_gnt", ((rvalid & ~gnt) == 2'b00), 1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int idx, input logic w, input logic [AW-1:0] a, input logic [RW-1:0] d);
    we[idx] = w;
    addr[idx*AW +: AW] = a;
    wdata[idx*RW +: RW] = d;
  endtask

  task automatic do_reset;
    rstb = 1'b0; ena = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    tick; tick;
    check("rst_gnt", gnt, 2'b00);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_bank_en", bank_en, 0);
    check("rst_bank_we", bank_we, 0);
    check("rst_bank_addr", bank_addr, 0);
    check("rst_bank_wdata", bank_wdata, 0);
    rstb = 1'b1;
    tick;
  endtask

  int seq [8];
  int tim [8];
  int k;
  int ones;
  int nb;
  int nr;
  logic [RW-1:0] cap;

  initial begin
    do_reset;

    // write A5 to reg 3, then read it back; each rvalid lands in the third cycle
    req = 2'b01; set_cmd(0, 1'b1, 4'd3, 8'hA5);
    tick; tick;
    check("wr_rvalid", rvalid, 2'b01);
    check("wr_rdata", rdata, 8'hA5);
    req = 2'b00;
    tick;
    req = 2'b01; set_cmd(0, 1'b0, 4'd3, 8'h00);
    tick;
    check("rd_gnt", gnt, 2'b01);
    tick;
    check("rd_rvalid", rvalid, 2'b01);
    check("rd_rdata", rdata, 8'hA5);
    req = 2'b00;
    tick;

    // both requesting continuously: grants alternate starting with requester 0
    do_reset;
    for (int i = 0; i < 8; i++) seq[i] = -1;
    k = 0;
    req = 2'b11; set_cmd(0, 1'b0, 4'd1, 8'h00); set_cmd(1, 1'b0, 4'd2, 8'h00);
    for (int c = 0; c < 20; c++) begin
      tick;
      if (rvalid != 2'b00 && k < 8) begin seq[k] = int'(rvalid[1]); k++; end
    end
    req = 2'b00;
    ones = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == 1) ones++;
    check("rr_0", seq[0], 0);
    check("rr_1", seq[1], 1);
    check("rr_2", seq[2], 0);
    check("rr_3", seq[3], 1);
    check("rr_share", ones, 2);
    tick;

    // locked burst for requester 1: four back-to-back completions, then release to 0
    do_reset;
    for (int i = 0; i < 8; i++) begin seq[i] = -1; tim[i] = -100; end
    k = 0;
    lock = 2'b10; req = 2'b11;
    set_cmd(0, 1'b0, 4'd4, 8'h00); set_cmd(1, 1'b1, 4'd6, 8'h5A);
    for (int c = 0; c < 30; c++) begin
      tick;
      if (rvalid != 2'b00 && k < 8) begin seq[k] = int'(rvalid[1]); tim[k] = c; k++; end
    end
    req = 2'b00; lock = 2'b00;
    check("burst_first", seq[0], 0);
    check("burst_b1", seq[1], 1);
    check("burst_b2", seq[2], 1);
    check("burst_b3", seq[3], 1);
    check("burst_b4", seq[4], 1);
    check("burst_release", seq[5], 0);
    check("burst_gap2", tim[2] - tim[1], 2);
    check("burst_gap3", tim[3] - tim[2], 2);
    check("burst_gap4", tim[4] - tim[3], 2);
    tick;

    // enable low for five cycles while in the bank cycle
    do_reset;
    req = 2'b01; set_cmd(0, 1'b0, 4'd5, 8'h00);
    tick;
    ena = 1'b0; req = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("frz_bank_en", bank_en, 0);
      check("frz_gnt", gnt, 2'b01);
      check("frz_rvalid", rvalid, 2'b00);
      tick;
    end
    ena = 1'b1;
    nb = 0; nr = 0; cap = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bank_en) nb++;
      if (rvalid[0]) begin nr++; cap = rdata; end
      tick;
    end
    check("frz_bank_pulses", nb, 1);
    check("frz_rvalid_pulses", nr, 1);
    check("frz_rdata", cap, 8'h15);

    // asynchronous reset in the response cycle, then requester 1 alone
    do_reset;
    req = 2'b01; set_cmd(0, 1'b0, 4'd2, 8'h00);
    tick; tick;
    check("arst_pre_rvalid", rvalid, 2'b01);
    rstb = 1'b0;
    #1;
    check("arst_rvalid", rvalid, 2'b00);
    check("arst_gnt", gnt, 2'b00);
    check("arst_bank_en", bank_en, 0);
    req = 2'b00;
    tick;
    rstb = 1'b1; req = 2'b10; set_cmd(1, 1'b1, 4'd9, 8'h3C);
    tick;
    check("arst_gnt1", gnt, 2'b10);
    tick;
    check("arst_rvalid1", rvalid, 2'b10);
    check("arst_rdata1", rdata, 8'h3C);
    req = 2'b00;
    tick;

    // request withdrawn during the bank cycle still completes once
    req = 2'b01; set_cmd(0, 1'b0, 4'd7, 8'h00);
    tick;
    req = 2'b00;
    tick;
    check("drop_rvalid", rvalid, 2'b01);
    check("drop_rdata", rdata, 8'h17);
    tick;
    check("drop_idle_gnt", gnt, 2'b00);
    check("drop_idle_rvalid", rvalid, 2'b00);
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
